// File: rtl/updown_pkg.sv
// Shared types and default sizes for the up/down sweep controller.
package updown_pkg;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_SWEEP_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/updown_counter_core.sv
// Loadable up/down counter holding the sweep count value.
module updown_counter_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             up_down,
   output logic [WIDTH-1:0] count
);

   // Count register: load wins over enable, direction chosen by up_down
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= din;
      end else if (en) begin
         count <= up_down ? count + WIDTH'(1) : count - WIDTH'(1);
      end
   end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep controller: runs n lo->hi->lo sweeps on an up/down counter.
module updown_sweep_ctrl
   import updown_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int SWEEP_W = DEF_SWEEP_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   lo,
   input  logic [WIDTH-1:0]   hi,
   input  logic [SWEEP_W-1:0] n_sweeps,
   output logic [WIDTH-1:0]   count,
   output logic               up_down,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [SWEEP_W-1:0] sweep_cnt
);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   lo_q, hi_q;
   logic [SWEEP_W-1:0] n_q;
   logic [SWEEP_W-1:0] sweep_nxt;
   logic               err_nxt;
   logic               capture;
   logic               cnt_en, cnt_load, cnt_up;

   // The counter always loads lo on an accepted start; the sweep boundary
   // step to lo+1 is a plain up-count from lo, so no extra adder is needed.
   updown_counter_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .reset   (reset),
      .en      (cnt_en),
      .load    (cnt_load),
      .din     (lo),
      .up_down (cnt_up),
      .count   (count)
   );

   // State, captured run parameters, sweep counter and error pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         lo_q      <= '0;
         hi_q      <= '0;
         n_q       <= '0;
         sweep_cnt <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         sweep_cnt <= sweep_nxt;
         err       <= err_nxt;
         if (capture) begin
            lo_q <= lo;
            hi_q <= hi;
            n_q  <= n_sweeps;
         end
      end
   end

   // Next-state and counter control; abort overrides everything when busy
   always_comb begin
      state_nxt = state;
      sweep_nxt = sweep_cnt;
      err_nxt   = 1'b0;
      capture   = 1'b0;
      cnt_en    = 1'b0;
      cnt_load  = 1'b0;
      cnt_up    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if ((lo < hi) && (n_sweeps != '0)) begin
                  capture   = 1'b1;
                  cnt_load  = 1'b1;
                  sweep_nxt = '0;
                  state_nxt = UP;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         UP: begin
            cnt_en = 1'b1;
            if (count != hi_q) begin
               cnt_up = 1'b1;
            end else begin
               cnt_up    = 1'b0;
               state_nxt = DOWN;
            end
         end
         DOWN: begin
            if (count != lo_q) begin
               cnt_en = 1'b1;
               cnt_up = 1'b0;
            end else begin
               sweep_nxt = sweep_cnt + SWEEP_W'(1);
               if ((sweep_cnt + SWEEP_W'(1)) == n_q) begin
                  state_nxt = DONE;
               end else begin
                  cnt_en    = 1'b1;
                  cnt_up    = 1'b1;
                  state_nxt = UP;
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         sweep_nxt = sweep_cnt;
         cnt_en    = 1'b0;
         cnt_load  = 1'b0;
      end
   end

   // Status outputs decoded from state
   always_comb begin
      up_down = (state == UP);
      busy    = (state == UP) || (state == DOWN);
      done    = (state == DONE);
   end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl: per-cycle vector table plus
// hand-written wide-range, and asynchronous-reset sequences.
module tb_updown_sweep_ctrl;

   localparam int WIDTH   = 4;
   localparam int SWEEP_W = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               abort;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   hi;
   logic [SWEEP_W-1:0] n_sweeps;
   logic [WIDTH-1:0]   count;
   logic               up_down;
   logic               busy;
   logic               done;
   logic               err;
   logic [SWEEP_W-1:0] sweep_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       start;
      logic       abort;
      logic [3:0] lo;
      logic [3:0] hi;
      logic [3:0] n;
      logic [3:0] count;
      logic       ud;
      logic       busy;
      logic       done;
      logic       err;
      logic [3:0] sc;
   } vec_t;

   vec_t tbl[$];

   updown_sweep_ctrl #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .lo        (lo),
      .hi        (hi),
      .n_sweeps  (n_sweeps),
      .count     (count),
      .up_down   (up_down),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .sweep_cnt (sweep_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic s, input logic a, input logic [3:0] l,
                               input logic [3:0] h, input logic [3:0] n,
                               input logic [3:0] c, input logic u, input logic b,
                               input logic d, input logic e, input logic [3:0] sc);
      vec_t v;
      v.start = s; v.abort = a; v.lo = l; v.hi = h; v.n = n;
      v.count = c; v.ud = u; v.busy = b; v.done = d; v.err = e; v.sc = sc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] c, input logic u,
                          input logic b, input logic d, input logic e,
                          input logic [3:0] sc);
      chk({tag, " count"},     32'(count),     32'(c));
      chk({tag, " up_down"},   32'(up_down),   32'(u));
      chk({tag, " busy"},      32'(busy),      32'(b));
      chk({tag, " done"},      32'(done),      32'(d));
      chk({tag, " err"},       32'(err),       32'(e));
      chk({tag, " sweep_cnt"}, 32'(sweep_cnt), 32'(sc));
   endtask

   initial begin
      // n=1 sweep, with a start while busy that must be ignored
      tbl.push_back(mk(1,0,2,5,1, 2,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 3,1,1,0,0,0));
      tbl.push_back(mk(1,0,0,9,3, 4,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 5,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 4,0,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 3,0,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 2,0,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 2,0,0,1,0,1));
      tbl.push_back(mk(0,0,2,5,1, 2,0,0,0,0,1));
      // rejected starts: lo==hi, n==0, lo>hi
      tbl.push_back(mk(1,0,5,5,1, 2,0,0,0,1,1));
      tbl.push_back(mk(0,0,5,5,1, 2,0,0,0,0,1));
      tbl.push_back(mk(1,0,2,5,0, 2,0,0,0,1,1));
      tbl.push_back(mk(0,0,2,5,0, 2,0,0,0,0,1));
      tbl.push_back(mk(1,0,7,3,2, 2,0,0,0,1,1));
      // n=2: second sweep restarts at 3, done 13 edges after accept
      tbl.push_back(mk(1,0,2,5,2, 2,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,2, 3,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,2, 4,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,2, 5,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,2, 4,0,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,2, 3,0,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,2, 2,0,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,2, 3,1,1,0,0,1));
      tbl.push_back(mk(0,0,2,5,2, 4,1,1,0,0,1));
      tbl.push_back(mk(0,0,2,5,2, 5,1,1,0,0,1));
      tbl.push_back(mk(0,0,2,5,2, 4,0,1,0,0,1));
      tbl.push_back(mk(0,0,2,5,2, 3,0,1,0,0,1));
      tbl.push_back(mk(0,0,2,5,2, 2,0,1,0,0,1));
      tbl.push_back(mk(0,0,2,5,2, 2,0,0,1,0,2));
      tbl.push_back(mk(0,0,2,5,2, 2,0,0,0,0,2));
      // abort in IDLE is ignored; abort at count 4 going up holds count
      tbl.push_back(mk(1,1,2,5,1, 2,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 3,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 4,1,1,0,0,0));
      tbl.push_back(mk(0,1,2,5,1, 4,0,0,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 4,0,0,0,0,0));
      // restart accepted, then abort while going down
      tbl.push_back(mk(1,0,2,5,1, 2,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 3,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 4,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 5,1,1,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 4,0,1,0,0,0));
      tbl.push_back(mk(0,1,2,5,1, 4,0,0,0,0,0));
      tbl.push_back(mk(0,0,2,5,1, 4,0,0,0,0,0));

      reset = 1'b1; start = 1'b0; abort = 1'b0;
      lo = '0; hi = '0; n_sweeps = '0;
      @(negedge clk);
      @(negedge clk);
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         start = tbl[i].start; abort = tbl[i].abort;
         lo = tbl[i].lo; hi = tbl[i].hi; n_sweeps = tbl[i].n;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].count, tbl[i].ud, tbl[i].busy,
                 tbl[i].done, tbl[i].err, tbl[i].sc);
      end

      // Full-range sweep 0..15..0: no wrap, DONE 31 edges after accept
      @(negedge clk);
      start = 1'b1; abort = 1'b0; lo = 4'd0; hi = 4'd15; n_sweeps = 4'd1;
      @(posedge clk);
      #1;
      chk("wide accept count", 32'(count), 32'd0);
      start = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("wide edge%0d count", e), 32'(count),
             32'((e <= 15) ? e : 30 - e));
         if (e == 15) chk("wide top up_down", 32'(up_down), 32'd1);
         if (e == 16) chk("wide turn up_down", 32'(up_down), 32'd0);
         chk($sformatf("wide edge%0d done", e), 32'(done), 32'd0);
      end
      @(posedge clk);
      #1;
      chk_all("wide done", 0, 0, 0, 1, 0, 1);
      @(posedge clk);
      #1;
      chk_all("wide idle", 0, 0, 0, 0, 0, 1);

      // Asynchronous reset in the middle of DOWN
      @(negedge clk);
      start = 1'b1; lo = 4'd2; hi = 4'd5; n_sweeps = 4'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int e = 0; e < 4; e++) begin
         @(posedge clk);
      end
      #1;
      chk("pre-reset count", 32'(count), 32'd4);
      chk("pre-reset direction down", 32'(up_down), 32'd0);
      chk("pre-reset busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_all("async reset", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk_all("held reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk_all("post-reset idle", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      chk_all("restart", 2, 1, 1, 0, 0, 0);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("restart step", 32'(count), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
